// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and helpers used by the digest streaming logic.
package sha256_pkg;

  localparam int SHA256_DIGEST_BITS = 256;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // Beats needed to emit a digest: one per byte raw, one per nibble in hex.
  function automatic int beat_count(input int digest_bits, input bit hex_ascii);
    return hex_ascii ? (digest_bits / 4) : (digest_bits / 8);
  endfunction

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h57 + {4'h0, nibble});
  endfunction

endpackage

// File: rtl/sha256_hex_encoder.sv
// Combinational nibble to lowercase ASCII hex character.
module sha256_hex_encoder
  import sha256_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  assign o_ascii = nibble_to_ascii(i_nibble);

endmodule

// File: rtl/sha256_digest_streamer.sv
// Captures a finished SHA-256 digest on the rising edge of hash_done and streams it
// MSB-first over an 8-bit valid/ready port, either as raw bytes or lowercase ASCII hex.
module sha256_digest_streamer
  import sha256_pkg::*;
#(
  parameter int DIGEST_BITS = SHA256_DIGEST_BITS,
  parameter bit HEX_ASCII   = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGEST_BITS-1:0] hash_in,
  input  logic                   hash_done,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int N     = beat_count(DIGEST_BITS, HEX_ASCII);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int STEP  = HEX_ASCII ? 4 : 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [0:0]             r_state;
  logic [DIGEST_BITS-1:0] r_shift;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_done_prev;
  logic                   r_overrun;
  logic [7:0]             r_out_data;
  logic                   r_out_last;

  logic                   w_streaming;
  logic                   w_cap;
  logic                   w_hs;
  logic                   w_final;
  logic                   w_load;
  logic                   w_adv;
  logic                   w_overrun_set;
  logic [IDX_W-1:0]       w_next_idx;
  logic [DIGEST_BITS-1:0] w_next_shift;
  logic [7:0]             w_beat;

  assign w_streaming   = (r_state == ST_STREAM);
  assign w_cap         = hash_done && !r_done_prev;
  assign w_hs          = w_streaming && out_ready;
  assign w_final       = w_hs && r_out_last;
  // A capture coinciding with the final handshake reloads back-to-back instead of dropping.
  assign w_load        = w_cap && (!w_streaming || w_final);
  assign w_adv         = w_hs && !r_out_last;
  assign w_overrun_set = w_cap && w_streaming && !w_final;

  assign w_next_idx   = w_load ? '0 : (r_idx + IDX_W'(1));
  assign w_next_shift = w_load ? hash_in : (r_shift << STEP);

  // The beat always comes from the MSBs of the next shift value, so no index mux is needed.
  if (HEX_ASCII) begin : g_hex
    sha256_hex_encoder u_hex_encoder (
      .i_nibble (w_next_shift[DIGEST_BITS-1 -: 4]),
      .o_ascii  (w_beat)
    );
  end else begin : g_raw
    assign w_beat = w_next_shift[DIGEST_BITS-1 -: 8];
  end

  // NOTE: the shift register carries no reset; nothing reads it until a capture loads it.
  always_ff @(posedge clk) begin
    if (w_load || w_adv) begin
      r_shift <= w_next_shift;
    end
  end

  // NOTE: every register here uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_done_prev <= 1'b0;
      r_overrun   <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      r_done_prev <= hash_done;

      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end

      if (w_load || w_adv) begin
        r_idx      <= w_next_idx;
        r_out_data <= w_beat;
        r_out_last <= (w_next_idx == IDX_W'(N - 1));
      end else if (w_final) begin
        r_out_last <= 1'b0;
      end

      if (w_load) begin
        r_state <= ST_STREAM;
      end else if (w_final) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = w_streaming;
  assign out_last  = r_out_last;
  assign busy      = w_streaming;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_sha256_digest_streamer.sv
// Self-checking bench: raw and hex streamers driven side by side against a beat model.
module tb_sha256_digest_streamer;

  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] hash_in;
  logic         hash_done;
  logic         out_ready;
  logic         overrun_clr;

  logic [7:0] r_data, h_data;
  logic       r_valid, h_valid, r_last, h_last, r_busy, h_busy, r_ovr, h_ovr;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];
  bit         rx_l[$];

  always #5 clk = ~clk;

  sha256_digest_streamer #(.DIGEST_BITS(256), .HEX_ASCII(1'b0)) u_raw (
    .clk(clk), .rst(rst), .hash_in(hash_in), .hash_done(hash_done),
    .out_data(r_data), .out_valid(r_valid), .out_ready(out_ready), .out_last(r_last),
    .busy(r_busy), .overrun(r_ovr), .overrun_clr(overrun_clr)
  );

  sha256_digest_streamer #(.DIGEST_BITS(256), .HEX_ASCII(1'b1)) u_hex (
    .clk(clk), .rst(rst), .hash_in(hash_in), .hash_done(hash_done),
    .out_data(h_data), .out_valid(h_valid), .out_ready(out_ready), .out_last(h_last),
    .busy(h_busy), .overrun(h_ovr), .overrun_clr(overrun_clr)
  );

  // Reference: beat k is byte k of the digest, or the ASCII of nibble k in hex mode.
  function automatic logic [7:0] exp_beat(input logic [255:0] d, input bit hex, input int k);
    logic [255:0] s;
    int n;
    if (!hex) begin
      s = d >> (248 - 8 * k);
      return s[7:0];
    end
    s = d >> (252 - 4 * k);
    n = int'(s[3:0]);
    return (n < 10) ? 8'(48 + n) : 8'(87 + n);
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d = '0;
    for (int i = 0; i < 8; i++) d = {d[223:0], 32'($urandom())};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; hash_done = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Collects handshaken beats until the final one; records stability violations.
  task automatic recv(input bit hex, input int pct, output int stab, output bit to);
    logic [7:0] pd, d;
    logic       pl, v, l;
    bit         held, rdy, fin;
    rx_q = {}; rx_l = {};
    stab = 0; held = 0; fin = 0; pd = '0; pl = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      v = hex ? h_valid : r_valid;
      d = hex ? h_data  : r_data;
      l = hex ? h_last  : r_last;
      rdy = ($urandom_range(99) < pct);
      if (v) begin
        if (held && (d !== pd || l !== pl)) stab++;
        if (rdy) begin
          rx_q.push_back(d);
          rx_l.push_back(l);
          if (l) fin = 1;
        end
        held = !rdy; pd = d; pl = l;
      end else begin
        held = 0;
      end
      out_ready = rdy;
      tick();
    end
    to = !fin;
  endtask

  task automatic test_reset();
    rst = 1'b1; hash_done = 1'b0; hash_in = '0; out_ready = 1'b1; overrun_clr = 1'b0;
    tick(); tick();
    n_vec++;
    if ({r_valid, r_last, r_busy, r_ovr, r_data} !== 12'h000 ||
        {h_valid, h_last, h_busy, h_ovr, h_data} !== 12'h000) begin
      n_err++;
      $display("FAIL reset: raw=%h hex=%h required 000",
               {r_valid, r_last, r_busy, r_ovr, r_data}, {h_valid, h_last, h_busy, h_ovr, h_data});
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (r_valid !== 1'b0 || h_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: valid raw=%b hex=%b required 0", r_valid, h_valid);
    end
  endtask

  task automatic test_stream(input bit hex);
    int nb = hex ? 64 : 32;
    logic [7:0] d;
    logic v, l, b;
    do_reset();
    out_ready = 1'b1; hash_in = ABC; hash_done = 1'b1;
    n_vec++;
    if ((hex ? h_valid : r_valid) !== 1'b0) begin
      n_err++;
      $display("FAIL early_valid: got 1 required 0 before the sampled edge");
    end
    tick();
    for (int k = 0; k < nb; k++) begin
      d = hex ? h_data : r_data; v = hex ? h_valid : r_valid;
      l = hex ? h_last : r_last; b = hex ? h_busy : r_busy;
      n_vec++;
      if (v !== 1'b1 || b !== 1'b1 || d !== exp_beat(ABC, hex, k) || l !== (k == nb - 1)) begin
        n_err++;
        $display("FAIL stream hex=%0d beat %0d: v=%b busy=%b data=%h last=%b required 1 1 %h %b",
                 hex, k, v, b, d, l, exp_beat(ABC, hex, k), (k == nb - 1));
      end
      tick();
    end
    v = hex ? h_valid : r_valid; b = hex ? h_busy : r_busy; l = hex ? h_last : r_last;
    n_vec++;
    if (v !== 1'b0 || b !== 1'b0 || l !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end hex=%0d: v=%b busy=%b last=%b required 0 0 0", hex, v, b, l);
    end
    hash_done = 1'b0;
    tick();
  endtask

  task automatic test_random_ready();
    logic [255:0] dig;
    int stab, nb;
    bit to, hex;
    for (int it = 0; it < 4; it++) begin
      hex = (it == 3);
      nb  = hex ? 64 : 32;
      dig = (it == 0) ? ABC : rand_digest();
      do_reset();
      hash_in = dig; hash_done = 1'b1;
      recv(hex, 50, stab, to);
      hash_done = 1'b0;
      n_vec++;
      if (to || stab != 0 || rx_q.size() != nb) begin
        n_err++;
        $display("FAIL rand_ready it%0d: timeout=%0d unstable=%0d beats=%0d required 0 0 %0d",
                 it, to, stab, rx_q.size(), nb);
      end
      for (int k = 0; k < rx_q.size() && k < nb; k++) begin
        n_vec++;
        if (rx_q[k] !== exp_beat(dig, hex, k) || rx_l[k] !== (k == nb - 1)) begin
          n_err++;
          $display("FAIL rand_ready it%0d beat %0d: data=%h last=%b required %h %b",
                   it, k, rx_q[k], rx_l[k], exp_beat(dig, hex, k), (k == nb - 1));
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [255:0] a = rand_digest();
    logic [255:0] b = rand_digest();
    int hs = 0, lasts = 0;
    // hash_done high through reset: captured in the first cycle after reset
    rst = 1'b1; hash_in = a; hash_done = 1'b1; out_ready = 1'b1; overrun_clr = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (r_valid !== 1'b1 || r_data !== exp_beat(a, 0, 0)) begin
      n_err++;
      $display("FAIL held_through_reset: v=%b data=%h required 1 %h", r_valid, r_data, exp_beat(a, 0, 0));
    end
    for (int c = 0; c < 99; c++) begin
      if (r_valid) begin
        hs++;
        if (r_last) lasts++;
      end
      tick();
    end
    n_vec++;
    if (hs != 32 || lasts != 1 || r_valid !== 1'b0 || r_ovr !== 1'b0) begin
      n_err++;
      $display("FAIL held_high: beats=%0d lasts=%0d valid=%b ovr=%b required 32 1 0 0",
               hs, lasts, r_valid, r_ovr);
    end
    hash_done = 1'b0;
    tick();
    hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (r_valid !== 1'b1 || r_data !== exp_beat(a, 0, k)) begin
        n_err++;
        $display("FAIL overrun_stream beat %0d: v=%b data=%h required 1 %h", k, r_valid, r_data, exp_beat(a, 0, k));
      end
      if (k == 5) begin hash_in = b; hash_done = 1'b1; end
      if (k == 6) hash_done = 1'b0;
      tick();
    end
    n_vec++;
    if (r_ovr !== 1'b1 || r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_set: ovr=%b valid=%b required 1 0", r_ovr, r_valid);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_vec++;
    if (r_ovr !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clr: ovr=%b required 0", r_ovr);
    end
    hash_in = a; hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    tick(); tick();
    hash_done = 1'b1; overrun_clr = 1'b1;
    tick();
    hash_done = 1'b0; overrun_clr = 1'b0;
    n_vec++;
    if (r_ovr !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_set_wins: ovr=%b required 1", r_ovr);
    end
    for (int c = 0; c < 64 && r_valid; c++) tick();
    n_vec++;
    if (r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_drain: valid=%b required 0 within budget", r_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] a = rand_digest();
    logic [255:0] b = rand_digest();
    do_reset();
    out_ready = 1'b1; hash_in = a; hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (r_valid !== 1'b1 || r_data !== exp_beat(a, 0, k) || r_last !== (k == 31)) begin
        n_err++;
        $display("FAIL b2b_first beat %0d: v=%b data=%h last=%b required 1 %h %b",
                 k, r_valid, r_data, r_last, exp_beat(a, 0, k), (k == 31));
      end
      if (k == 31) begin hash_in = b; hash_done = 1'b1; end
      tick();
    end
    hash_done = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (r_valid !== 1'b1 || r_data !== exp_beat(b, 0, k) || r_last !== (k == 31) || r_ovr !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_second beat %0d: v=%b data=%h last=%b ovr=%b required 1 %h %b 0",
                 k, r_valid, r_data, r_last, r_ovr, exp_beat(b, 0, k), (k == 31));
      end
      tick();
    end
    n_vec++;
    if (r_valid !== 1'b0 || r_ovr !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: valid=%b ovr=%b required 0 0", r_valid, r_ovr);
    end
  endtask

  task automatic test_mid_reset();
    logic [255:0] a = rand_digest();
    logic [255:0] c = rand_digest();
    do_reset();
    out_ready = 1'b1; hash_in = a; hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    n_vec++;
    if (r_data !== exp_beat(a, 0, 10)) begin
      n_err++;
      $display("FAIL mid_reset_pre: data=%h required %h", r_data, exp_beat(a, 0, 10));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (r_valid !== 1'b0 || r_busy !== 1'b0 || r_last !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: v=%b busy=%b last=%b required 0 0 0", r_valid, r_busy, r_last);
    end
    tick();
    hash_in = c; hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_vec++;
      if (r_valid !== 1'b1 || r_data !== exp_beat(c, 0, k) || r_last !== (k == 31)) begin
        n_err++;
        $display("FAIL after_reset beat %0d: v=%b data=%h last=%b required 1 %h %b",
                 k, r_valid, r_data, r_last, exp_beat(c, 0, k), (k == 31));
      end
      tick();
    end
    n_vec++;
    if (r_valid !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset_end: valid=%b required 0", r_valid);
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_random_ready();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
